// File: rtl/shift_pkg.sv
// Shared types for the pipelined shifter: op encoding and the per-stage control payload.
// Operand data and the decoded amount travel beside the payload since their width is a parameter.
package shift_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OpSll = 3'b000,
      OpSrl = 3'b001,
      OpSra = 3'b010,
      OpRol = 3'b011,
      OpRor = 3'b100,
      OpRsv = 3'b101
   } shift_op_e;

   typedef struct packed {
      shift_op_e op;
      logic      ovf;
      logic      sign;
      logic      carry;
      logic      valid;
   } shift_ctl_t;

   function automatic logic is_saturating(shift_op_e op);
      return (op == OpSll) || (op == OpSrl) || (op == OpSra);
   endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One log-shifter stage: shifts or rotates by 2**K when amount bit K is set, then registers.
// Rotate wrap muxes exist only when SHIFT_PIPE_ROTATE_EN is defined.
module shift_pipe_stage
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned K     = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     adv_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic [$clog2(WIDTH)-1:0] amt_i,
   input  shift_ctl_t               ctl_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(WIDTH)-1:0] amt_o,
   output shift_ctl_t               ctl_o
);

   localparam int unsigned Sh = 1 << K;

   logic [WIDTH-1:0]         data_d, data_q;
   logic [$clog2(WIDTH)-1:0] amt_q;
   shift_ctl_t               ctl_q;

   // Saturated ops were already forced to their fill value at pre-decode.
   always_comb begin
      data_d = data_i;
      if (amt_i[K] && !ctl_i.ovf) begin
         unique case (ctl_i.op)
            OpSll:   data_d = data_i << Sh;
            OpSrl:   data_d = data_i >> Sh;
            OpSra:   data_d = {{Sh{ctl_i.sign}}, data_i[WIDTH-1:Sh]};
`ifdef SHIFT_PIPE_ROTATE_EN
            OpRol:   data_d = {data_i[WIDTH-Sh-1:0], data_i[WIDTH-1:WIDTH-Sh]};
            OpRor:   data_d = {data_i[Sh-1:0], data_i[WIDTH-1:Sh]};
`endif
            default: data_d = data_i;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         amt_q  <= '0;
         ctl_q  <= '0;
      end else if (adv_i) begin
         data_q <= data_d;
         amt_q  <= amt_i;
         ctl_q  <= ctl_i;
      end
   end

   assign data_o = data_q;
   assign amt_o  = amt_q;
   assign ctl_o  = ctl_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shifter: a registered pre-decode followed by $clog2(WIDTH) log stages, full backpressure.
// Define SHIFT_PIPE_ROTATE_EN to implement ROL/ROR; otherwise they behave as reserved ops.
module shift_pipe
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [OP_W-1:0]  in_op_i,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_carry_o,
   output logic             out_zero_o
);

   localparam int unsigned      SHAMT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WidthV  = WIDTH'(WIDTH);

   shift_op_e          op_d;
   logic               ovf, gt_w, sign, sat, carry_d, adv;
   logic [SHAMT_W-1:0] amt, idx_l, idx_r;
   logic [WIDTH-1:0]   data_d;
   shift_ctl_t         ctl_d;

   logic [WIDTH-1:0]   pre_data_q;
   logic [SHAMT_W-1:0] pre_amt_q;
   shift_ctl_t         pre_ctl_q;

   logic [WIDTH-1:0]   data_s [SHAMT_W+1];
   logic [SHAMT_W-1:0] amt_s  [SHAMT_W+1];
   shift_ctl_t         ctl_s  [SHAMT_W+1];

   assign amt   = in_b_i[SHAMT_W-1:0];
   assign ovf   = |in_b_i[WIDTH-1:SHAMT_W];
   assign gt_w  = in_b_i > WidthV;
   assign sign  = in_a_i[WIDTH-1];
   // Bit indices of the last bit shifted out, taken mod WIDTH so b == WIDTH lands on the edge bit.
   assign idx_l = SHAMT_W'(0) - amt;
   assign idx_r = amt - SHAMT_W'(1);

   always_comb begin
      unique case (in_op_i)
         OpSll:   op_d = OpSll;
         OpSrl:   op_d = OpSrl;
         OpSra:   op_d = OpSra;
`ifdef SHIFT_PIPE_ROTATE_EN
         OpRol:   op_d = OpRol;
         OpRor:   op_d = OpRor;
`endif
         default: op_d = OpRsv;
      endcase

      sat    = ovf && is_saturating(op_d);
      data_d = in_a_i;
      if (sat) data_d = (op_d == OpSra) ? {WIDTH{sign}} : '0;

      carry_d = 1'b0;
      if (in_b_i != '0) begin
         unique case (op_d)
            OpSll:   carry_d = !gt_w && in_a_i[idx_l];
            OpSrl:   carry_d = !gt_w && in_a_i[idx_r];
            OpSra:   carry_d = gt_w ? sign : in_a_i[idx_r];
`ifdef SHIFT_PIPE_ROTATE_EN
            OpRol:   carry_d = in_a_i[idx_l];
            OpRor:   carry_d = in_a_i[idx_r];
`endif
            default: carry_d = 1'b0;
         endcase
      end

      ctl_d = '{op: op_d, ovf: sat, sign: sign, carry: carry_d, valid: in_valid_i};
   end

   assign adv        = !out_valid_o || out_ready_i;
   assign in_ready_o = !rst_i && adv;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_data_q <= '0;
         pre_amt_q  <= '0;
         pre_ctl_q  <= '0;
      end else if (adv) begin
         pre_data_q <= data_d;
         pre_amt_q  <= amt;
         pre_ctl_q  <= ctl_d;
      end
   end

   assign data_s[0] = pre_data_q;
   assign amt_s[0]  = pre_amt_q;
   assign ctl_s[0]  = pre_ctl_q;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      shift_pipe_stage #(
         .WIDTH (WIDTH),
         .K     (k)
      ) u_stage (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .adv_i  (adv),
         .data_i (data_s[k]),
         .amt_i  (amt_s[k]),
         .ctl_i  (ctl_s[k]),
         .data_o (data_s[k+1]),
         .amt_o  (amt_s[k+1]),
         .ctl_o  (ctl_s[k+1])
      );
   end

   assign out_valid_o = ctl_s[SHAMT_W].valid;
   assign out_data_o  = data_s[SHAMT_W];
   assign out_carry_o = ctl_s[SHAMT_W].carry;
   assign out_zero_o  = out_valid_o && (data_s[SHAMT_W] == '0);

   logic unused_tail;
   assign unused_tail = ^{amt_s[SHAMT_W], ctl_s[SHAMT_W].op, ctl_s[SHAMT_W].ovf,
                          ctl_s[SHAMT_W].sign};

endmodule
